hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage in-order RISC-V core. Drives stall/flush controls into the fetch/decode, decode/execute and execute/memory pipeline registers, selects execute-stage operand forwarding, and holds the pipeline while a multi-cycle (mul/div) operation occupies execute. It also keeps saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side view of the hazard controller.
// Carries hazard inputs in and stall/flush/forwarding controls out.
interface hazard_ctrl_if;
    logic [4:0] ad1d;
    logic [4:0] ad2d;
    logic [4:0] ad1e;
    logic [4:0] ad2e;
    logic [4:0] rde;
    logic [4:0] rdm;
    logic [4:0] rdw;
    logic       regWrtm;
    logic       regWrtw;
    logic [1:0] resltSrce;
    logic       pcSrce;
    logic       mde;
    logic       stallf;
    logic       stalld;
    logic       stalle;
    logic       flushd;
    logic       flushe;
    logic       flushm;
    logic [1:0] fwdAe;
    logic [1:0] fwdBe;
    logic       mdDone;

    modport master (
        output ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw,
        output regWrtm, regWrtw, resltSrce, pcSrce, mde,
        input  stallf, stalld, stalle, flushd, flushe, flushm,
        input  fwdAe, fwdBe, mdDone
    );

    modport slave (
        input  ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw,
        input  regWrtm, regWrtw, resltSrce, pcSrce, mde,
        output stallf, stalld, stalle, flushd, flushe, flushm,
        output fwdAe, fwdBe, mdDone
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage core,
// multi-cycle execute sequencing and saturating perf counters.
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MD_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             w_mdStall;
    logic             w_mdDone;
    logic             w_lwStall;
    logic             w_stallf;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Memory-stage result wins over writeback; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] ad,
                                           input logic       wm,
                                           input logic [4:0] rm,
                                           input logic       ww,
                                           input logic [4:0] rw);
        logic [1:0] s;
        s = 2'b00;
        if (ad != 5'd0) begin
            if (wm && (rm == ad))
                s = 2'b10;
            else if (ww && (rw == ad))
                s = 2'b01;
        end
        return s;
    endfunction

    // Operand forwarding selects for execute.
    always_comb begin
        hz.fwdAe = fwd_sel(hz.ad1e, hz.regWrtm, hz.rdm,
                           hz.regWrtw, hz.rdw);
        hz.fwdBe = fwd_sel(hz.ad2e, hz.regWrtm, hz.rdm,
                           hz.regWrtw, hz.rdw);
    end

    // Load in execute feeding an instruction in decode.
    always_comb begin
        w_lwStall = (hz.resltSrce == 2'b01) && (hz.rde != 5'd0) &&
                    ((hz.rde == hz.ad1d) || (hz.rde == hz.ad2d));
    end

    // Multi-cycle state register; cnt holds remaining busy cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Multi-cycle next state and stall/done decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mdStall   = 1'b0;
        w_mdDone    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (hz.mde) begin
                    if (MD_LAT > 1) begin
                        w_mdStall   = 1'b1;
                        w_cnt_nxt   = LAT_M1;
                        w_state_nxt = BUSY;
                    end else begin
                        w_mdDone = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (r_cnt > 4'd1) begin
                    w_mdStall = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_mdDone    = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Pipeline controls; a taken branch overrides every stall.
    always_comb begin
        w_stallf  = !hz.pcSrce && (w_lwStall || w_mdStall);
        hz.stallf = w_stallf;
        hz.stalld = w_stallf;
        hz.stalle = !hz.pcSrce && w_mdStall;
        hz.flushd = hz.pcSrce;
        hz.flushe = hz.pcSrce || (w_lwStall && !w_mdStall);
        hz.flushm = w_mdStall;
        hz.mdDone = w_mdDone;
    end

    // Saturating stall and flush counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallf && (r_stallCnt != '1))
                r_stallCnt <= r_stallCnt + 1'b1;
            if (hz.pcSrce && (r_flushCnt != '1))
                r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    assign stallCnt = r_stallCnt;
    assign flushCnt = r_flushCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random checks of hazard_ctrl against
// a cycle-index reference model (MD_LAT=4/CNT_W=32 and MD_LAT=1/CNT_W=4).
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    logic [31:0] stallCntA;
    logic [31:0] flushCntA;
    logic [3:0]  stallCntB;
    logic [3:0]  flushCntB;

    int n_chk;
    int n_err;

    bit     a_busy;
    int     a_pos;
    longint a_nst;
    longint a_nfl;
    bit     b_busy;
    int     b_pos;
    longint b_nst;
    longint b_nfl;

    hazard_ctrl_if hif ();
    hazard_ctrl_if hifb ();

    assign hifb.ad1d      = hif.ad1d;
    assign hifb.ad2d      = hif.ad2d;
    assign hifb.ad1e      = hif.ad1e;
    assign hifb.ad2e      = hif.ad2e;
    assign hifb.rde       = hif.rde;
    assign hifb.rdm       = hif.rdm;
    assign hifb.rdw       = hif.rdw;
    assign hifb.regWrtm   = hif.regWrtm;
    assign hifb.regWrtw   = hif.regWrtw;
    assign hifb.resltSrce = hif.resltSrce;
    assign hifb.pcSrce    = hif.pcSrce;
    assign hifb.mde       = hif.mde;

    hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .hz       (hif.slave),
        .stallCnt (stallCntA),
        .flushCnt (flushCntA)
    );

    hazard_ctrl #(.MD_LAT(1), .CNT_W(4)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .hz       (hifb.slave),
        .stallCnt (stallCntB),
        .flushCnt (flushCntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] ad);
        if (ad != 0 && hif.regWrtm && hif.rdm == ad) return 2'b10;
        if (ad != 0 && hif.regWrtw && hif.rdw == ad) return 2'b01;
        return 2'b00;
    endfunction

    function automatic longint sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // pos = cycles elapsed since the op entered execute.
    task automatic m_md(input int lat, input bit busy, input int pos,
                        input bit mde, output bit st, output bit dn);
        if (!busy) begin
            st = mde && (lat > 1);
            dn = mde && (lat == 1);
        end else begin
            st = (pos < lat - 1);
            dn = (pos == lat - 1);
        end
    endtask

    task automatic m_adv(input int lat, input bit mde,
                         inout bit busy, inout int pos);
        if (busy) begin
            if (pos == lat - 1) begin
                busy = 1'b0;
                pos  = 0;
            end else begin
                pos++;
            end
        end else if (mde && lat > 1) begin
            busy = 1'b1;
            pos  = 1;
        end
    endtask

    task automatic chk_ctl(input string p, input bit lw,
                           input bit st, input bit dn,
                           input logic sf, input logic sd,
                           input logic se, input logic fd,
                           input logic fe, input logic fm,
                           input logic md, output bit exp_sf);
        bit pc;
        pc = hif.pcSrce;
        exp_sf = !pc && (lw || st);
        chk({p, ".stallf"}, sf, exp_sf);
        chk({p, ".stalld"}, sd, exp_sf);
        chk({p, ".stalle"}, se, !pc && st);
        chk({p, ".flushd"}, fd, pc);
        chk({p, ".flushe"}, fe, pc || (lw && !st));
        chk({p, ".flushm"}, fm, st);
        chk({p, ".mdDone"}, md, dn);
    endtask

    task automatic step();
        bit lw;
        bit sa;
        bit da;
        bit sb;
        bit db;
        bit sfa;
        bit sfb;
        #1;
        lw = (hif.resltSrce == 2'b01) && (hif.rde != 0) &&
             ((hif.rde == hif.ad1d) || (hif.rde == hif.ad2d));
        m_md(4, a_busy, a_pos, hif.mde, sa, da);
        m_md(1, b_busy, b_pos, hif.mde, sb, db);
        chk("A.fwdAe", hif.fwdAe, m_fwd(hif.ad1e));
        chk("A.fwdBe", hif.fwdBe, m_fwd(hif.ad2e));
        chk("B.fwdAe", hifb.fwdAe, m_fwd(hif.ad1e));
        chk("B.fwdBe", hifb.fwdBe, m_fwd(hif.ad2e));
        chk_ctl("A", lw, sa, da, hif.stallf, hif.stalld, hif.stalle,
                hif.flushd, hif.flushe, hif.flushm, hif.mdDone, sfa);
        chk_ctl("B", lw, sb, db, hifb.stallf, hifb.stalld,
                hifb.stalle, hifb.flushd, hifb.flushe, hifb.flushm,
                hifb.mdDone, sfb);
        @(posedge clk);
        if (sfa) a_nst++;
        if (sfb) b_nst++;
        if (hif.pcSrce) begin
            a_nfl++;
            b_nfl++;
        end
        m_adv(4, hif.mde, a_busy, a_pos);
        m_adv(1, hif.mde, b_busy, b_pos);
        #1;
        chk("A.stallCnt", stallCntA, sat(a_nst, 32));
        chk("A.flushCnt", flushCntA, sat(a_nfl, 32));
        chk("B.stallCnt", stallCntB, sat(b_nst, 4));
        chk("B.flushCnt", flushCntB, sat(b_nfl, 4));
        @(negedge clk);
    endtask

    task automatic m_reset();
        a_busy = 0; a_pos = 0; a_nst = 0; a_nfl = 0;
        b_busy = 0; b_pos = 0; b_nst = 0; b_nfl = 0;
    endtask

    task automatic zero_in();
        hif.ad1d = 0; hif.ad2d = 0; hif.ad1e = 0; hif.ad2e = 0;
        hif.rde = 0; hif.rdm = 0; hif.rdw = 0;
        hif.regWrtm = 0; hif.regWrtw = 0; hif.resltSrce = 0;
        hif.pcSrce = 0; hif.mde = 0;
    endtask

    task automatic rand_in();
        hif.ad1d = 5'($urandom_range(0, 3));
        hif.ad2d = 5'($urandom_range(0, 3));
        hif.ad1e = 5'($urandom_range(0, 3));
        hif.ad2e = 5'($urandom_range(0, 3));
        hif.rde  = 5'($urandom_range(0, 3));
        hif.rdm  = 5'($urandom_range(0, 3));
        hif.rdw  = 5'($urandom_range(0, 3));
        hif.regWrtm   = 1'($urandom);
        hif.regWrtw   = 1'($urandom);
        hif.resltSrce = 2'($urandom);
        hif.pcSrce    = ($urandom_range(0, 5) == 0);
        hif.mde       = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        m_reset();
        zero_in();
        rst = 1'b1;
        #12;
        @(negedge clk);
        chk("rst.stallf", hif.stallf, 0);
        chk("rst.fwdAe", hif.fwdAe, 0);
        chk("rst.stallCnt", stallCntA, 0);
        rst = 1'b0;
        step();

        // forwarding: memory over writeback, x0 never forwarded
        hif.regWrtm = 1; hif.rdm = 5; hif.regWrtw = 1; hif.rdw = 5;
        hif.ad1e = 5; hif.ad2e = 0;
        #1;
        chk("fwd.mem", hif.fwdAe, 2'b10);
        chk("fwd.x0", hif.fwdBe, 2'b00);
        step();
        hif.regWrtm = 0;
        #1;
        chk("fwd.wb", hif.fwdAe, 2'b01);
        step();
        zero_in();

        // load-use
        hif.resltSrce = 2'b01; hif.rde = 7; hif.ad2d = 7;
        #1;
        chk("lw.stallf", hif.stallf, 1);
        chk("lw.flushe", hif.flushe, 1);
        step();
        hif.rde = 0; hif.ad2d = 0;
        #1;
        chk("lw.rd0", hif.stallf, 0);
        step();
        zero_in();

        // multi-cycle: mde held, two back-to-back sequences
        hif.mde = 1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("md.stalle", hif.stalle, (c % 4) != 3);
            chk("md.done", hif.mdDone, (c % 4) == 3);
            step();
        end
        hif.mde = 0;
        step();

        // branch overrides load-use
        hif.resltSrce = 2'b01; hif.rde = 7; hif.ad1d = 7;
        hif.pcSrce = 1;
        #1;
        chk("br.stallf", hif.stallf, 0);
        chk("br.flushe", hif.flushe, 1);
        step();
        chk("br.flushCnt", flushCntA, 1);
        zero_in();

        // reset during BUSY
        hif.mde = 1;
        step();
        hif.mde = 0;
        rst = 1'b1;
        #1;
        chk("rstmd.stalle", hif.stalle, 0);
        chk("rstmd.mdDone", hif.mdDone, 0);
        chk("rstmd.stallCnt", stallCntA, 0);
        chk("rstmd.flushCnt", flushCntA, 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hif.mde = 1;
        #1;
        chk("rstmd.restart", hif.stalle, 1);
        for (int c = 0; c < 4; c++) step();
        zero_in();

        // saturation on the 4-bit counters
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hif.resltSrce = 2'b01; hif.rde = 3; hif.ad1d = 3;
        for (int c = 0; c < 20; c++) step();
        chk("sat.B", stallCntB, 4'd15);
        chk("sat.A", stallCntA, 20);
        zero_in();

        for (int c = 0; c < 3000; c++) begin
            rand_in();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
